mux_tree_pipe: RTL and testbench
================================

# mux_tree_pipe

Parametrised, pipelined N:1 multiplexer tree that selects one of N WIDTH-bit channels per cycle. It is built from levels of 2:1 selection with a register after every level. A valid bit travels with each sample, and each result is tagged with its source channel index. An optional scan mode walks the channels round-robin, so a downstream sampler can serialise all inputs without driving a select.

## Interface
- WIDTH, 8, data bits per channel (>=1)
- N, 8, channel count; power of two, >=2
- LVLS (localparam), log2(N), tree depth and pipeline latency
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- din  in  N*WIDTH  flattened channels; channel k at din[k*WIDTH +: WIDTH]
- sel  in  LVLS  channel select, used when not scanning
- in_valid  in  1  sample qualifier for the current din/sel
- scan_en  in  1  1 = use internal scan counter instead of sel
- dout  out  WIDTH  selected channel data
- dout_ch  out  LVLS  channel index that produced dout
- out_valid  out  1  dout/dout_ch qualifier, one-cycle strobe per sample

## Operation
- Effective select: esel = scan_en ? scan_cnt : sel, evaluated in the cycle in_valid=1.
- Level j (j=0..LVLS-1) does 2:1 selection on pairs from the previous level, using esel bit j: bit 0 = 0 takes the even element, bit 0 = 1 takes the odd element. Level 0 operates on din directly.
- Level j registers hold:
  - N>>(j+1) partial results,
  - the remaining select bits,
  - the full esel, carried as the channel tag,
  - a valid bit.
- Valid pipeline advances every cycle, with no stall or backpressure.
- Data and tag registers of a level load only when that level's incoming valid is 1. Otherwise they hold.
- dout and dout_ch therefore keep the last valid sample through bubbles.
- scan_cnt (LVLS bits):
  - increments by 1 on every cycle with in_valid=1 and scan_en=1,
  - wraps from N-1 to 0,
  - holds otherwise,
  - is never loaded from sel.
- Select bits are used only as indices below N. No out-of-range case exists because N is a power of two.

## Timing
- Reset (async, rst=1): all pipeline registers, dout, dout_ch, out_valid and scan_cnt are 0 immediately, not at the next edge.
- Latency: a sample accepted at edge t (in_valid=1 before edge t) appears with out_valid=1 after edge t+LVLS-1, i.e. LVLS registers. For N=2 the latency is 1.
- Throughput: one sample per cycle. Back-to-back valid samples leave back-to-back, in order.
- out_valid mirrors the in_valid pattern delayed by LVLS cycles, bubbles included.
- Mid-operation reset: all in-flight samples are discarded. No out_valid is produced for them after rst deasserts.
- First edge after rst deasserts: normal operation. Scanning starts at channel 0.
- scan_en changes take effect for the sample accepted at that edge. Samples already in flight keep the tag they were captured with.

## Configuration
- MUX_TREE_SCAN_EN defined: scan_cnt and the scan_en path are compiled in, as described above.
- MUX_TREE_SCAN_EN undefined:
  - no scan counter exists,
  - scan_en is ignored (port kept for a stable interface),
  - esel = sel always.

## Test plan
- WIDTH=8, N=8, all channels at din channel k = 0x10+k. sel=5 with in_valid pulsed for 1 cycle -> exactly one out_valid strobe 3 cycles later, with dout=0x15 and dout_ch=5.
- Same din, sel stepped 0..7 on 8 consecutive valid cycles -> out_valid high for 8 consecutive cycles, dout 0x10..0x17 in order, dout_ch 0..7.
- Macro defined, scan_en=1, sel=3, in_valid=1 for 10 cycles -> dout_ch sequence 0,1,2,3,4,5,6,7,0,1 (wrap), dout=0x10+dout_ch, sel ignored.
- in_valid pattern 1,0,1 with sel=2 then sel=6 -> out_valid 1,0,1. dout holds 0x12 during the bubble, then shows 0x16.
- rst asserted for 1 cycle while 2 samples are in flight -> out_valid, dout, dout_ch read 0 immediately. No strobe afterwards. The next scan sample is channel 0.
- Macro undefined, scan_en=1, sel=4, one valid sample -> dout=0x14, dout_ch=4.

Source files
------------

// File: rtl/mux_tree_pipe_if.sv
// Channel/select/result bundle for mux_tree_pipe.
// The master drives the channels and the select. The slave returns the tagged result.
interface mux_tree_pipe_if #(
    parameter int WIDTH = 8,
    parameter int N     = 8
);
    localparam int LVLS = $clog2(N);

    logic [N*WIDTH-1:0] din;
    logic [LVLS-1:0]    sel;
    logic               in_valid;
    logic               scan_en;
    logic [WIDTH-1:0]   dout;
    logic [LVLS-1:0]    dout_ch;
    logic               out_valid;

    modport master (
        output din, sel, in_valid, scan_en,
        input  dout, dout_ch, out_valid
    );

    modport slave (
        input  din, sel, in_valid, scan_en,
        output dout, dout_ch, out_valid
    );
endinterface

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree: LVLS levels of registered 2:1 selection, each carrying a valid bit and a channel tag.
// Optional round-robin scan counter is enabled by defining MUX_TREE_SCAN_EN.
module mux_tree_pipe #(
    parameter int WIDTH = 8,
    parameter int N     = 8
) (
    input  logic           clk,
    input  logic           rst,
    mux_tree_pipe_if.slave bus
);
    localparam int LVLS = $clog2(N);

    logic [LVLS-1:0] esel;

`ifdef MUX_TREE_SCAN_EN
    logic [LVLS-1:0] scan_cnt;

    // Wraps from N-1 to 0 for free, because N is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            scan_cnt <= '0;
        else if (bus.in_valid && bus.scan_en)
            scan_cnt <= scan_cnt + 1'b1;
    end

    assign esel = bus.scan_en ? scan_cnt : bus.sel;
`else
    logic unused_scan_en;
    assign unused_scan_en = bus.scan_en;
    assign esel           = bus.sel;
`endif

    // The tree is a heap. Node i has children 2i and 2i+1. Leaves N..2N-1 are the channels.
    logic [WIDTH-1:0] node_q [1:N-1];
    logic [WIDTH-1:0] node   [1:2*N-1];
    logic [LVLS-1:0]  tag_q  [LVLS];
    logic [LVLS-1:0]  tag_in [LVLS];
    logic [LVLS-1:0]  vld_q;
    logic [LVLS-1:0]  vld_in;

    always_comb begin
        for (int i = 1; i < N; i++)
            node[i] = node_q[i];
        for (int k = 0; k < N; k++)
            node[N+k] = bus.din[k*WIDTH +: WIDTH];
    end

    always_comb begin
        tag_in[0] = esel;
        vld_in[0] = bus.in_valid;
        for (int j = 1; j < LVLS; j++) begin
            tag_in[j] = tag_q[j-1];
            vld_in[j] = vld_q[j-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every level samples its predecessor's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data array is reset too, because dout must read 0 during reset, not stale data.
            for (int i = 1; i < N; i++)
                node_q[i] <= '0;
            for (int j = 0; j < LVLS; j++)
                tag_q[j] <= '0;
            vld_q <= '0;
        end else begin
            vld_q <= vld_in;
            for (int j = 0; j < LVLS; j++) begin
                if (vld_in[j]) begin
                    tag_q[j] <= tag_in[j];
                    // Level j owns heap nodes N>>(j+1) .. (N>>j)-1 and steers on tag bit j.
                    for (int i = N >> (j + 1); i < (N >> j); i++)
                        node_q[i] <= tag_in[j][j] ? node[2*i+1] : node[2*i];
                end
            end
        end
    end

    assign bus.dout      = node_q[1];
    assign bus.dout_ch   = tag_q[LVLS-1];
    assign bus.out_valid = vld_q[LVLS-1];
endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe (WIDTH=8, N=8): the driver queues expected results and a negedge monitor checks them.
module tb_mux_tree_pipe;
    localparam int WIDTH = 8;
    localparam int N     = 8;
    localparam int LVLS  = 3;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [LVLS-1:0]  ch;
        int               cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc      = 0;
    int   nchecks  = 0;
    int   nfail    = 0;
    exp_t sb[$];
    logic [WIDTH-1:0] last_d  = '0;
    logic [LVLS-1:0]  last_ch = '0;
    logic [LVLS-1:0]  scan_seq [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

    mux_tree_pipe_if #(.WIDTH(WIDTH), .N(N)) bus ();

    mux_tree_pipe #(.WIDTH(WIDTH), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop on every strobe, otherwise confirm the outputs hold the last result.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                nchecks++;
                nfail++;
                $display("FAIL unexpected_strobe: dout=0x%0h dout_ch=%0d with no sample pending (cycle %0d)",
                         bus.dout, bus.dout_ch, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dout", 32'(bus.dout), 32'(e.d));
                check("dout_ch", 32'(bus.dout_ch), 32'(e.ch));
                check("latency", 32'(cyc), 32'(e.cyc));
                last_d  = e.d;
                last_ch = e.ch;
            end
        end else begin
            check("hold_dout", 32'(bus.dout), 32'(last_d));
            check("hold_dout_ch", 32'(bus.dout_ch), 32'(last_ch));
        end
    end

    task automatic send(input logic [LVLS-1:0] s, input logic sc,
                        input logic [WIDTH-1:0] ed, input logic [LVLS-1:0] ech);
        exp_t e;
        bus.sel      = s;
        bus.scan_en  = sc;
        bus.in_valid = 1'b1;
        e.d   = ed;
        e.ch  = ech;
        e.cyc = cyc + LVLS;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.scan_en  = 1'b0;
        bus.sel      = '0;
        for (int k = 0; k < N; k++)
            bus.din[k*WIDTH +: WIDTH] = 8'(8'h10 + k);
        #1 rst = 1'b1;
        #1;
        check("reset_dout", 32'(bus.dout), 32'h0);
        check("reset_dout_ch", 32'(bus.dout_ch), 32'h0);
        check("reset_out_valid", 32'(bus.out_valid), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Single sample.
        send(3'd5, 1'b0, 8'h15, 3'd5);
        idle(5);

        // Back-to-back sweep of every channel.
        for (int k = 0; k < N; k++)
            send(3'(k), 1'b0, 8'(8'h10 + k), 3'(k));
        idle(5);

        // One-cycle bubble between two samples: dout must hold 0x12 through the gap.
        send(3'd2, 1'b0, 8'h12, 3'd2);
        idle(1);
        send(3'd6, 1'b0, 8'h16, 3'd6);
        idle(5);

`ifdef MUX_TREE_SCAN_EN
        // Ten scan samples with sel parked at 3: the counter walks 0..7 and wraps.
        for (int i = 0; i < 10; i++)
            send(3'd3, 1'b1, 8'(8'h10 + scan_seq[i]), scan_seq[i]);
`else
        // No scan hardware: scan_en is ignored and sel wins.
        send(3'd4, 1'b1, 8'h14, 3'd4);
`endif
        drain("drain_scan");
        idle(2);

        // Mid-flight reset: two samples are in the pipe when rst rises.
        send(3'd1, 1'b0, 8'h11, 3'd1);
        send(3'd2, 1'b0, 8'h12, 3'd2);
        rst = 1'b1;
        sb.delete();
        last_d  = '0;
        last_ch = '0;
        #1;
        check("midrst_dout", 32'(bus.dout), 32'h0);
        check("midrst_dout_ch", 32'(bus.dout_ch), 32'h0);
        check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(6);

`ifdef MUX_TREE_SCAN_EN
        // The counter stood at 2 before the reset and must restart at channel 0.
        send(3'd5, 1'b1, 8'h10, 3'd0);
`else
        send(3'd4, 1'b1, 8'h14, 3'd4);
`endif
        drain("drain_after_reset");
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end
endmodule
